// File: rtl/mdu_if.sv
// mdu_if: start/operand/result bundle between the execute stage and mdu_seq.
// master = issuing stage, slave = mdu_seq.
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] MDUResult;
    logic            Zero;
    logic            Sign_Flag;

    modport master (
        output start, op, A, B,
        input  busy, done, MDUResult, Zero, Sign_Flag
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, MDUResult, Zero, Sign_Flag
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit (shift-add multiplier,
// restoring divider, XLEN iterations). Result and Zero/Sign_Flag registered.
// Optional build macro MDU_EARLY_OUT_EN: divide by zero, signed overflow and
// multiply by zero bypass CALC and go straight to FIX.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_S   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_IT = CW'(XLEN - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;   // multiplicand, or divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;     // mul: {hi, multiplier}; div: {rem, quo}
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sneg_q, sneg_d;     // result (product/quotient) negated
    logic              aneg_q, aneg_d;     // remainder negated
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic              mulz_q, mulz_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zero_q, zero_d;
    logic              sign_q, sign_d;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div0_in, ovf_in, mulz_in;

    // Decode operand signedness and special cases of the incoming request
    always_comb begin
        a_sgn   = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_sgn   = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg   = a_sgn & bus.A[XLEN-1];
        b_neg   = b_sgn & bus.B[XLEN-1];
        mag_a   = a_neg ? -bus.A : bus.A;
        mag_b   = b_neg ? -bus.B : bus.B;
        div0_in = bus.op[2] & (bus.B == '0);
        ovf_in  = bus.op[2] & ~bus.op[0] & (bus.A == MIN_S) & (bus.B == '1);
        mulz_in = ~bus.op[2] & ((bus.A == '0) | (bus.B == '0));
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   div_sh;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_step, div_step;

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_step  = {mul_sum, prod_q[XLEN-1:1]};
        div_sh    = {prod_q, 1'b0};
        div_trial = div_sh[2*XLEN:XLEN] - {1'b0, mcand_q};
        if (!div_trial[XLEN])
            div_step = {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
        else
            div_step = div_sh[2*XLEN-1:0];
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Sign correction, special-case override and result selection
    always_comb begin
        prod_fix = sneg_q ? -prod_q : prod_q;
        quo_fix  = sneg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_fix  = aneg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        case (op_q)
            3'b000:                 fix_res = mulz_q ? '0 : prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = mulz_q ? '0 : prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = div0_q ? '1 : (ovf_q ? a_q : quo_fix);
            default:                fix_res = div0_q ? a_q : (ovf_q ? '0 : rem_fix);
        endcase
    end

    // Next-state logic: accept, iterate, fix up, report
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        sneg_d  = sneg_q;
        aneg_d  = aneg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        mulz_d  = mulz_q;
        res_d   = res_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.A;
                    mcand_d = bus.op[2] ? mag_b : mag_a;
                    prod_d  = {{XLEN{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
                    cnt_d   = '0;
                    sneg_d  = a_neg ^ b_neg;
                    aneg_d  = a_neg;
                    div0_d  = div0_in;
                    ovf_d   = ovf_in;
                    mulz_d  = mulz_in;
`ifdef MDU_EARLY_OUT_EN
                    state_d = (div0_in | ovf_in | mulz_in) ? FIX : CALC;
`else
                    state_d = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d  = cnt_q + CW'(1);
                prod_d = op_q[2] ? div_step : mul_step;
                if (cnt_q == LAST_IT)
                    state_d = FIX;
            end
            FIX: begin
                res_d   = fix_res;
                zero_d  = (fix_res == '0);
                sign_d  = fix_res[XLEN-1];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            sneg_q  <= 1'b0;
            aneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mulz_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            sneg_q  <= sneg_d;
            aneg_q  <= aneg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            mulz_q  <= mulz_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
        end
    end

    assign bus.busy      = (state_q == CALC) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);
    assign bus.MDUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Sign_Flag = sign_q;
endmodule
